multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
- Multi-cycle main controller for the RV32I subset core: load, store, R-type, I-type ALU, beq/bne, jalr.
- Sequences one shared ALU and one single-port unified memory through fetch/decode/execute/memory/writeback states.
- Waits on a memory ready handshake, counts retired instructions, and traps on unsupported opcodes.

Parameters:
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- instr  in  32  instruction register contents; valid from DECODE onward
- EQ  in  1  ALU equality flag (rs1 == rs2)
- mem_ready  in  1  memory access completes this cycle
- PCWrite  out  1  PC register load enable
- PCsrc  out  1  PC next: 0 = ALU result, 1 = ALUOut register
- IRWrite  out  1  instruction register load enable
- AdrSrc  out  1  memory address: 0 = PC, 1 = ALUOut
- MemWrite  out  1  memory write strobe
- RegWrite  out  1  register file write enable
- ALUSrcA  out  2  00 = PC, 01 = oldPC, 10 = rs1
- ALUSrcB  out  2  00 = rs2, 01 = imm, 10 = constant 4
- ALUOp  out  2  00 = add, 01 = compare/sub, 10 = decode funct
- ImmSrc  out  3  immediate format
- ResultSrc  out  2  register write data: 00 = ALUOut, 01 = mem data, 10 = PC
- retired  out  CNT_W  retired-instruction count
- state_o  out  4  current state encoding, for debug
- trap  out  1  sticky illegal-opcode flag

Behaviour:
- Decoded fields: op = instr[6:0], funct3 = instr[14:12].
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC_R=6, EXEC_I=7, ALUWB=8, BRANCH=9, JALR=10, TRAP=15.
- Reset (asynchronous, rst_n=0): state=FETCH, retired=0, trap=0.
  - All outputs then take their FETCH values with mem_ready treated as 0.
  - All write enables are therefore 0 during reset.
- Unlisted outputs in each state are 0.
- ImmSrc is combinational from op in every state: load/I-type 000, store 001, branch 010, jalr 100, otherwise 000.
- Per-state outputs and next state:
  - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, PCsrc=0.
    - mem_ready=1: IRWrite=1, PCWrite=1 (Mealy), next DECODE.
    - mem_ready=0: remain in FETCH with no write enables.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00, so the branch target lands in ALUOut. Next state by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXEC_R
    - 0010011 -> EXEC_I
    - 1100011 -> BRANCH
    - 1100111 -> JALR
    - any other op -> TRAP
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next MEMRD if op=0000011, else MEMWR.
  - MEMRD: AdrSrc=1. Hold until mem_ready=1, then MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1. Next FETCH; retire.
  - MEMWR: AdrSrc=1, MemWrite=1 held every cycle in the state. On mem_ready=1 go to FETCH; retire on that cycle.
  - EXEC_R: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next ALUWB.
  - EXEC_I: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1. Next FETCH; retire.
  - BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, PCsrc=1.
    - PCWrite = EQ for funct3=000, !EQ for 001, 0 for any other funct3.
    - Next FETCH; retire.
  - JALR: ALUSrcA=10, ALUSrcB=01, ALUOp=00, PCsrc=0, PCWrite=1, RegWrite=1, ResultSrc=10.
    - rd receives the already-incremented PC, i.e. old PC+4.
    - Next FETCH; retire.
  - TRAP: trap=1 and all enables 0. Remains in TRAP until reset.
- Retire: retired increments by 1 on the clock edge that leaves the last state of an instruction. It wraps modulo 2^CNT_W.
- Cycle counts with mem_ready tied to 1:
  - load 5; store 4; R-type/I-type 4; branch 3; jalr 3.
  - Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds 1.
- mem_ready is ignored in every state other than FETCH, MEMRD and MEMWR.
- Reset asserted mid-instruction:
  - MemWrite and RegWrite drop immediately (asynchronously).
  - The partially completed instruction is not counted.
  - trap clears.

Test Plan:
- Reset, then add x3,x1,x2 (0x002081B3) with mem_ready=1 -> state sequence 0,1,6,8,0; RegWrite high only in ALUWB; retired=1.
- lw (op 0000011) with mem_ready low for 3 cycles in FETCH and 2 in MEMRD -> 10 cycles total; IRWrite pulses exactly once; ResultSrc=01 in MEMWB; retired=1.
- beq with EQ=1, then beq with EQ=0, then bne with EQ=0 -> PCWrite=1, 0, 1 in BRANCH with PCsrc=1; each takes 3 cycles.
- jalr (0x000080E7) -> JALR state has PCWrite=1, RegWrite=1, ResultSrc=10, ImmSrc=100; next state FETCH.
- sw with rst_n pulsed low while in MEMWR and mem_ready=0 -> MemWrite falls in the same cycle; state_o=0; retired unchanged at 0.
- Opcode 0x7F -> state_o=15, trap=1, enables stay 0 for 20 cycles; reset clears trap and state returns to FETCH.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Main FSM controller for a multi-cycle RV32I subset core.
// Shared ALU and single-port memory sequencing, ready handshake, retire counter and illegal-opcode trap.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr,
  input  logic             EQ,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCsrc,
  output logic             IRWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [2:0]       ImmSrc,
  output logic [1:0]       ResultSrc,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state_o,
  output logic             trap
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2, S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC_R = 4'd6, S_EXEC_I = 4'd7,
    S_ALUWB  = 4'd8,  S_BRANCH = 4'd9,  S_JALR   = 4'd10, S_TRAP  = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BRAN  = 7'b1100011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q;
  logic             trap_q;
  logic             retire_s;
  logic             mem_rdy_s;
  logic [6:0]       op_s;
  logic [2:0]       funct3_s;
  logic             unused_bits_s;

  assign op_s          = instr[6:0];
  assign funct3_s      = instr[14:12];
  assign unused_bits_s = ^{instr[31:15], instr[11:7]};
  // Reset must look like FETCH with no memory completion, so no write enable leaks out.
  assign mem_rdy_s     = mem_ready & rst_n;

  // Next-state, retire strobe and control decode from the current state.
  always_comb begin
    state_d   = state_q;
    retire_s  = 1'b0;
    PCWrite   = 1'b0;
    PCsrc     = 1'b0;
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    ResultSrc = 2'b00;
    case (op_s)
      OP_LOAD, OP_ITYPE: ImmSrc = 3'b000;
      OP_STORE:          ImmSrc = 3'b001;
      OP_BRAN:           ImmSrc = 3'b010;
      OP_JALR:           ImmSrc = 3'b100;
      default:           ImmSrc = 3'b000;
    endcase
    case (state_q)
      S_FETCH: begin
        ALUSrcB = 2'b10;
        if (mem_rdy_s) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op_s)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXEC_R;
          OP_ITYPE:          state_d = S_EXEC_I;
          OP_BRAN:           state_d = S_BRANCH;
          OP_JALR:           state_d = S_JALR;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (op_s == OP_LOAD) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        AdrSrc  = 1'b1;
        state_d = mem_rdy_s ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        state_d   = S_FETCH;
        retire_s  = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (mem_rdy_s) begin
          state_d  = S_FETCH;
          retire_s = 1'b1;
        end else begin
          state_d  = S_MEMWR;
        end
      end
      S_EXEC_R: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_EXEC_I: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
        retire_s = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        PCsrc   = 1'b1;
        case (funct3_s)
          3'b000:  PCWrite = EQ;
          3'b001:  PCWrite = ~EQ;
          default: PCWrite = 1'b0;
        endcase
        state_d  = S_FETCH;
        retire_s = 1'b1;
      end
      S_JALR: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        PCWrite   = 1'b1;
        RegWrite  = 1'b1;
        ResultSrc = 2'b10;
        state_d   = S_FETCH;
        retire_s  = 1'b1;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  // State, retire counter and sticky trap flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      retired_q <= {CNT_W{1'b0}};
      trap_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (retire_s) begin
        retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        retired_q <= retired_q;
      end
      trap_q <= trap_q | (state_d == S_TRAP);
    end
  end

  assign retired = retired_q;
  assign state_o = state_q;
  assign trap    = trap_q;

endmodule
